closed_list_ctrl: RTL and testbench
===================================

# closed_list_ctrl

Controller for the A* closed-list store: owns the (x,y) coordinate memory and its linear search engine, and shares them between two requesters: the neighbour-check stage (lookup) and the node-expansion stage (insert). Requests are arbitrated round-robin and served one at a time. Each operation scans the list one entry per cycle. Inserts are duplicate-checked before they write.

## Interface
- DEPTH, 400, closed-list capacity in entries
- CW, 8, coordinate width (x and y each)
- IW, 9, index/count width; must satisfy 2^IW > DEPTH
- Clk  in  1  clock; all logic on rising edge
- Reset_n  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous list flush; empties the list
- lk_valid  in  1  lookup request
- lk_ready  out  1  lookup accepted when lk_valid && lk_ready
- lk_x, lk_y  in  CW  lookup coordinate, sampled at accept
- lk_done  out  1  one-cycle result pulse
- lk_found  out  1  hit flag, valid with lk_done
- lk_index  out  IW  hit index; 0 on miss
- ins_valid  in  1  insert request
- ins_ready  out  1  insert accepted when ins_valid && ins_ready
- ins_x, ins_y  in  CW  insert coordinate, sampled at accept
- ins_done  out  1  one-cycle completion pulse
- ins_status  out  2  00 ADDED, 01 DUPLICATE, 10 FULL; valid with ins_done
- count  out  IW  number of valid entries
- busy  out  1  high whenever state != IDLE

## Operation
- States: IDLE, SCAN, WRITE, RESP.
- IDLE:
  - lk_ready and ins_ready follow their valids under arbitration; both are low when clear=1.
  - Only one request is granted per accept.
  - If one requester is valid, it is granted.
  - If both are valid, the requester not granted last time wins.
  - The last-grant register resets to "insert", so lookup wins the first tie.
  - On accept: latch the op and coordinates, set idx=0, go to SCAN.
- SCAN:
  - If idx == count, the result is a miss.
  - Otherwise compare mem[idx] with the latched (x,y):
    - Equal: hit, latch idx.
    - Not equal: idx <= idx+1 and stay in SCAN.
  - Lookup: hit or miss goes to RESP.
  - Insert hit: goes to RESP with DUPLICATE.
  - Insert miss with count == DEPTH: goes to RESP with FULL.
  - Insert miss otherwise: goes to WRITE.
  - DUPLICATE takes priority over FULL.
- WRITE: mem[count] <= (x,y), count <= count+1, go to RESP with ADDED.
- RESP: pulse done plus result outputs for one cycle, go to IDLE. Result outputs hold their values until the next done.
- clear:
  - In any state, clear sets count=0 and returns to IDLE.
  - An in-flight operation is aborted with no done pulse; the requester re-issues.
  - Memory contents are not erased; only count defines validity.
- Reset: state IDLE, count 0, every output 0 (ready outputs, done, found, index, status, busy).
- Reset during an operation aborts it identically to clear.
- Memory is not reset.
- Widths: idx and count are IW bits and are compared unsigned. count never exceeds DEPTH.

## Timing
- Accept occurs at cycle 0. SCAN occupies cycles 1 onward.
- Lookup hit at index k: done at cycle k+2.
- Lookup miss with count=N: done at cycle N+2. An empty list gives done at cycle 2.
- Insert ADDED with count=N: done at cycle N+3, and count increments in the same cycle that done is seen.
- Insert DUPLICATE at index k: done at cycle k+2.
- Insert FULL: done at cycle DEPTH+2.
- Back-to-back operation: the earliest next accept is the cycle after RESP, so the minimum gap between accepts is 3 cycles.
- clear asserted in the same cycle as a valid request: no accept occurs.

## Structure
- Package closed_list_pkg:
  - state enum: IDLE, SCAN, WRITE, RESP
  - status codes: ST_ADDED, ST_DUP, ST_FULL
  - default DEPTH, CW, IW
- Sub-module closed_list_mem:
  - DEPTH × 2·CW register file
  - one combinational read port addressed by idx
  - one synchronous write port
  - no reset
- Arbiter, FSM and count live in closed_list_ctrl.

## Test plan
- After reset, insert (3,4) → ins_done at cycle 3, ins_status=00, count=1. Lookup (3,4) → lk_done at cycle 2, lk_found=1, lk_index=0.
- Insert (1,1), (2,2), (5,7), then lookup (9,9) → miss: lk_done at cycle 5, lk_found=0, lk_index=0. Re-insert (2,2) → ins_status=01, count unchanged.
- Fill 400 distinct entries. Insert a new coordinate → status=10 at cycle 402, count=400. Insert an existing coordinate → status=01.
- Hold lk_valid and ins_valid high continuously → grants alternate lookup, insert, lookup, …, with the first grant to lookup.
- Assert clear during SCAN of a 10-entry list → no done pulse, count=0, busy low the next cycle. A subsequent lookup of an old entry misses.
- Assert Reset_n low mid-WRITE → count=0 and all outputs 0 asynchronously. After release, normal accept works.

Source files
------------

// File: rtl/closed_list_pkg.sv
// closed_list_pkg: shared FSM states, insert status codes and default sizes
package closed_list_pkg;
  localparam int DEF_DEPTH = 400;
  localparam int DEF_CW = 8;
  localparam int DEF_IW = 9;
  typedef enum logic [1:0] {IDLE, SCAN, WRITE, RESP} state_t;
  localparam logic [1:0] ST_ADDED = 2'b00;
  localparam logic [1:0] ST_DUP = 2'b01;
  localparam logic [1:0] ST_FULL = 2'b10;
endpackage

// File: rtl/closed_list_if.sv
// closed_list_if: lookup/insert request channels plus list status
interface closed_list_if import closed_list_pkg::*; #(
  parameter int CW = DEF_CW,
  parameter int IW = DEF_IW
);
  logic clear;
  logic lk_valid, lk_ready, lk_done, lk_found;
  logic [CW-1:0] lk_x, lk_y;
  logic [IW-1:0] lk_index;
  logic ins_valid, ins_ready, ins_done;
  logic [CW-1:0] ins_x, ins_y;
  logic [1:0] ins_status;
  logic [IW-1:0] count;
  logic busy;
  modport master (
    output clear, lk_valid, lk_x, lk_y, ins_valid, ins_x, ins_y,
    input lk_ready, lk_done, lk_found, lk_index, ins_ready, ins_done, ins_status, count, busy
  );
  modport slave (
    input clear, lk_valid, lk_x, lk_y, ins_valid, ins_x, ins_y,
    output lk_ready, lk_done, lk_found, lk_index, ins_ready, ins_done, ins_status, count, busy
  );
endinterface

// File: rtl/closed_list_mem.sv
// closed_list_mem: coordinate register file, async read, sync write, no reset
module closed_list_mem import closed_list_pkg::*; #(
  parameter int DEPTH = DEF_DEPTH,
  parameter int W = 2 * DEF_CW,
  parameter int AW = DEF_IW
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);
  logic [W-1:0] mem [DEPTH];
  // store one entry on write enable
  always_ff @(posedge clk) if (we_i) mem[waddr_i] <= wdata_i;
  assign rdata_o = mem[raddr_i];
endmodule

// File: rtl/closed_list_ctrl.sv
// closed_list_ctrl: round-robin lookup/insert arbiter over a linearly scanned closed list
module closed_list_ctrl import closed_list_pkg::*; #(
  parameter int DEPTH = DEF_DEPTH,
  parameter int CW = DEF_CW,
  parameter int IW = DEF_IW
) (
  input logic Clk,
  input logic Reset_n,
  closed_list_if.slave bus
);
  state_t state_q, state_d;
  logic op_q, op_d, last_q, last_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic [IW-1:0] idx_q, idx_d, count_q, count_d, lki_q, lki_d;
  logic lkf_q, lkf_d, we, lk_go, ins_go, miss, hit;
  logic [1:0] st_q, st_d;
  logic [2*CW-1:0] rdata;
  closed_list_mem #(.DEPTH(DEPTH), .W(2*CW), .AW(IW)) u_mem (
    .clk(Clk), .we_i(we), .waddr_i(count_q), .wdata_i({x_q, y_q}),
    .raddr_i(idx_q), .rdata_o(rdata)
  );
  assign lk_go = Reset_n && state_q == IDLE && !bus.clear && bus.lk_valid && (!bus.ins_valid || last_q);
  assign ins_go = Reset_n && state_q == IDLE && !bus.clear && bus.ins_valid && (!bus.lk_valid || !last_q);
  assign miss = idx_q == count_q;
  assign hit = !miss && rdata == {x_q, y_q};
  assign bus.lk_ready = lk_go;
  assign bus.ins_ready = ins_go;
  assign bus.lk_done = state_q == RESP && !op_q && !bus.clear;
  assign bus.ins_done = state_q == RESP && op_q && !bus.clear;
  assign bus.lk_found = lkf_q;
  assign bus.lk_index = lki_q;
  assign bus.ins_status = st_q;
  assign bus.count = count_q;
  assign bus.busy = state_q != IDLE;
  // state, operands, count and held results
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      op_q <= 1'b0;
      last_q <= 1'b1;
      x_q <= '0;
      y_q <= '0;
      idx_q <= '0;
      count_q <= '0;
      lkf_q <= 1'b0;
      lki_q <= '0;
      st_q <= ST_ADDED;
    end else begin
      state_q <= state_d;
      op_q <= op_d;
      last_q <= last_d;
      x_q <= x_d;
      y_q <= y_d;
      idx_q <= idx_d;
      count_q <= count_d;
      lkf_q <= lkf_d;
      lki_q <= lki_d;
      st_q <= st_d;
    end
  end
  // arbitration, scan sequencing and result capture on entry to RESP
  always_comb begin
    state_d = state_q;
    op_d = op_q;
    last_d = last_q;
    x_d = x_q;
    y_d = y_q;
    idx_d = idx_q;
    count_d = count_q;
    lkf_d = lkf_q;
    lki_d = lki_q;
    st_d = st_q;
    we = 1'b0;
    case (state_q)
      IDLE: if (lk_go || ins_go) begin
        state_d = SCAN;
        op_d = ins_go;
        last_d = ins_go;
        x_d = ins_go ? bus.ins_x : bus.lk_x;
        y_d = ins_go ? bus.ins_y : bus.lk_y;
        idx_d = '0;
      end
      SCAN: if (hit || miss) begin
        state_d = (op_q && miss && count_q != IW'(DEPTH)) ? WRITE : RESP;
        lkf_d = op_q ? lkf_q : hit;
        lki_d = op_q ? lki_q : (hit ? idx_q : '0);
        st_d = !op_q ? st_q : (hit ? ST_DUP : (count_q == IW'(DEPTH) ? ST_FULL : st_q));
      end else idx_d = idx_q + 1'b1;
      WRITE: begin
        we = 1'b1;
        count_d = count_q + 1'b1;
        st_d = ST_ADDED;
        state_d = RESP;
      end
      default: state_d = IDLE;
    endcase
    if (bus.clear) begin
      state_d = IDLE;
      count_d = '0;
      we = 1'b0;
      lkf_d = lkf_q;
      lki_d = lki_q;
      st_d = st_q;
    end
  end
endmodule

// File: tb/tb_closed_list_ctrl.sv
// tb_closed_list_ctrl: directed checks of latency, results, arbitration, clear and reset
module tb_closed_list_ctrl;
  logic Clk = 1'b0;
  logic Reset_n = 1'b0;
  int vectors = 0;
  int errs = 0;
  int lat, n, k, bad, seen;
  int g [4];
  logic f;
  logic [8:0] ix, cn;
  logic [1:0] st;
  closed_list_if #(.CW(8), .IW(9)) bus ();
  closed_list_ctrl #(.DEPTH(400), .CW(8), .IW(9)) dut (.Clk(Clk), .Reset_n(Reset_n), .bus(bus));
  always #5 Clk = ~Clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle_inputs;
    bus.clear = 1'b0;
    bus.lk_valid = 1'b0;
    bus.ins_valid = 1'b0;
    bus.lk_x = '0;
    bus.lk_y = '0;
    bus.ins_x = '0;
    bus.ins_y = '0;
  endtask

  task automatic do_reset;
    @(negedge Clk);
    Reset_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge Clk);
    Reset_n = 1'b1;
  endtask

  task automatic op(input bit ins, input logic [7:0] x, input logic [7:0] y,
                    output int l, output logic fo, output logic [8:0] io,
                    output logic [1:0] so, output logic [8:0] co);
    int m;
    @(negedge Clk);
    if (ins) begin
      bus.ins_valid = 1'b1;
      bus.ins_x = x;
      bus.ins_y = y;
    end else begin
      bus.lk_valid = 1'b1;
      bus.lk_x = x;
      bus.lk_y = y;
    end
    #1;
    m = 0;
    while (!(ins ? bus.ins_ready : bus.lk_ready) && m < 50) begin
      @(negedge Clk);
      m++;
    end
    if (m == 50) chk("accept_timeout", 0, 1);
    @(posedge Clk);
    #1;
    bus.ins_valid = 1'b0;
    bus.lk_valid = 1'b0;
    m = 1;
    @(negedge Clk);
    while (!(ins ? bus.ins_done : bus.lk_done) && m < 1000) begin
      @(negedge Clk);
      m++;
    end
    l = (m < 1000) ? m : -1;
    fo = bus.lk_found;
    io = bus.lk_index;
    so = bus.ins_status;
    co = bus.count;
  endtask

  initial begin
    idle_inputs();
    bus.lk_valid = 1'b1;
    bus.ins_valid = 1'b1;
    repeat (2) @(negedge Clk);
    chk("rst_lk_ready", bus.lk_ready, 0);
    chk("rst_ins_ready", bus.ins_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_count", bus.count, 0);
    chk("rst_dones", {bus.lk_done, bus.ins_done}, 0);
    chk("rst_results", {bus.lk_found, bus.lk_index, bus.ins_status}, 0);
    idle_inputs();
    @(negedge Clk);
    Reset_n = 1'b1;

    op(1, 3, 4, lat, f, ix, st, cn);
    chk("ins34_lat", lat, 3);
    chk("ins34_status", st, 0);
    chk("ins34_count", cn, 1);
    @(negedge Clk);
    chk("ins_done_pulse", bus.ins_done, 0);
    op(0, 3, 4, lat, f, ix, st, cn);
    chk("lk34_lat", lat, 2);
    chk("lk34_found", f, 1);
    chk("lk34_index", ix, 0);

    @(negedge Clk);
    bus.clear = 1'b1;
    bus.lk_valid = 1'b1;
    #1;
    chk("clear_blocks_ready", bus.lk_ready, 0);
    @(posedge Clk);
    #1;
    chk("clear_no_accept", bus.busy, 0);
    chk("clear_count", bus.count, 0);
    idle_inputs();

    op(1, 1, 1, lat, f, ix, st, cn);
    chk("ins11_lat", lat, 3);
    op(1, 2, 2, lat, f, ix, st, cn);
    chk("ins22_lat", lat, 4);
    op(1, 5, 7, lat, f, ix, st, cn);
    chk("ins57_lat", lat, 5);
    chk("ins57_count", cn, 3);
    op(0, 9, 9, lat, f, ix, st, cn);
    chk("lk99_lat", lat, 5);
    chk("lk99_found", f, 0);
    chk("lk99_index", ix, 0);
    op(0, 5, 7, lat, f, ix, st, cn);
    chk("lk57_lat", lat, 4);
    chk("lk57_index", ix, 2);
    op(1, 2, 2, lat, f, ix, st, cn);
    chk("dup22_lat", lat, 3);
    chk("dup22_status", st, 1);
    chk("dup22_count", cn, 3);

    do_reset();
    @(negedge Clk);
    bus.lk_valid = 1'b1;
    bus.lk_x = 7;
    bus.lk_y = 7;
    bus.ins_valid = 1'b1;
    bus.ins_x = 8;
    bus.ins_y = 8;
    #1;
    k = 0;
    n = 0;
    while (k < 4 && n < 60) begin
      if (bus.lk_ready && bus.ins_ready) chk("tie_double_grant", 1, 0);
      if (bus.lk_ready || bus.ins_ready) begin
        g[k] = bus.ins_ready ? 1 : 0;
        k++;
      end
      if (k < 4) begin
        @(negedge Clk);
        n++;
      end
    end
    @(posedge Clk);
    #1;
    idle_inputs();
    repeat (8) @(negedge Clk);
    chk("tie_grants", k, 4);
    chk("tie_g0_lookup", g[0], 0);
    chk("tie_g1_insert", g[1], 1);
    chk("tie_g2_lookup", g[2], 0);
    chk("tie_g3_insert", g[3], 1);

    do_reset();
    for (int i = 0; i < 10; i++) op(1, 8'(i), 100, lat, f, ix, st, cn);
    chk("ten_count", cn, 10);
    @(negedge Clk);
    bus.lk_valid = 1'b1;
    bus.lk_x = 9;
    bus.lk_y = 100;
    #1;
    chk("scan_lk_ready", bus.lk_ready, 1);
    @(posedge Clk);
    #1;
    bus.lk_valid = 1'b0;
    repeat (3) @(negedge Clk);
    chk("scan_busy", bus.busy, 1);
    bus.clear = 1'b1;
    @(posedge Clk);
    #1;
    bus.clear = 1'b0;
    @(negedge Clk);
    chk("abort_busy", bus.busy, 0);
    chk("abort_count", bus.count, 0);
    seen = 0;
    repeat (15) begin
      if (bus.lk_done) seen = 1;
      @(negedge Clk);
    end
    chk("abort_no_done", seen, 0);
    op(0, 0, 100, lat, f, ix, st, cn);
    chk("stale_lat", lat, 2);
    chk("stale_found", f, 0);

    do_reset();
    op(1, 1, 1, lat, f, ix, st, cn);
    op(1, 2, 2, lat, f, ix, st, cn);
    op(0, 2, 2, lat, f, ix, st, cn);
    chk("pre_lk_index", ix, 1);
    op(1, 1, 1, lat, f, ix, st, cn);
    chk("pre_dup_status", st, 1);
    @(negedge Clk);
    bus.ins_valid = 1'b1;
    bus.ins_x = 3;
    bus.ins_y = 3;
    @(posedge Clk);
    #1;
    bus.ins_valid = 1'b0;
    repeat (4) @(negedge Clk);
    chk("write_busy", bus.busy, 1);
    Reset_n = 1'b0;
    #1;
    chk("arst_count", bus.count, 0);
    chk("arst_busy", bus.busy, 0);
    chk("arst_outputs", {bus.lk_done, bus.ins_done, bus.lk_found, bus.lk_index, bus.ins_status, bus.lk_ready, bus.ins_ready}, 0);
    @(negedge Clk);
    Reset_n = 1'b1;
    op(1, 1, 2, lat, f, ix, st, cn);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_status", st, 0);
    chk("post_rst_count", cn, 1);

    do_reset();
    bad = 0;
    for (int i = 0; i < 400; i++) begin
      op(1, 8'(i), 8'(i >> 8), lat, f, ix, st, cn);
      if (st !== 2'b00 || lat != i + 3) bad++;
    end
    chk("fill_all_added", bad, 0);
    chk("fill_count", cn, 400);
    op(1, 255, 255, lat, f, ix, st, cn);
    chk("full_lat", lat, 402);
    chk("full_status", st, 2);
    chk("full_count", cn, 400);
    op(1, 5, 0, lat, f, ix, st, cn);
    chk("full_dup_lat", lat, 7);
    chk("full_dup_status", st, 1);
    op(0, 143, 1, lat, f, ix, st, cn);
    chk("last_lk_lat", lat, 401);
    chk("last_lk_index", ix, 399);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end
endmodule
